// File: rtl/xadac_pkg.sv
// Shared types for the accelerator dispatch block: payload structs and route-table entry.
package xadac_pkg;

   localparam int unsigned IdWidth = 3;
   localparam int unsigned MaxMst  = 8;
   localparam int unsigned PortW   = $clog2(MaxMst);

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [31:0]        instr;
   } dec_req_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic               accept;
      logic [3:0]         flags;
   } dec_rsp_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [31:0]        opa;
   } exe_req_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [31:0]        result;
   } exe_rsp_t;

   // Port index is sized for the largest supported fan-out.
   typedef struct packed {
      logic             valid;
      logic [PortW-1:0] port;
   } route_t;

endpackage

// File: rtl/xadac_if.sv
// Core-to-accelerator decode/execute handshake bundle.
interface xadac_if;
   import xadac_pkg::*;

   logic     dec_req_valid;
   logic     dec_req_ready;
   dec_req_t dec_req;
   logic     dec_rsp_valid;
   logic     dec_rsp_ready;
   dec_rsp_t dec_rsp;
   logic     exe_req_valid;
   logic     exe_req_ready;
   exe_req_t exe_req;
   logic     exe_rsp_valid;
   logic     exe_rsp_ready;
   exe_rsp_t exe_rsp;

   modport slv (
      input  dec_req_valid, dec_req,
      output dec_req_ready,
      output dec_rsp_valid, dec_rsp,
      input  dec_rsp_ready,
      input  exe_req_valid, exe_req,
      output exe_req_ready,
      output exe_rsp_valid, exe_rsp,
      input  exe_rsp_ready
   );

   // Dispatcher side of an accelerator link; decode completion is tracked via dec_rsp.
   modport mst (
      output dec_req_valid, dec_req,
      output dec_rsp_ready,
      input  dec_rsp_valid, dec_rsp,
      output exe_req_valid, exe_req,
      input  exe_req_ready,
      input  exe_rsp_valid, exe_rsp,
      output exe_rsp_ready
   );

endinterface

// File: rtl/xadac_rr_arb.sv
// Round-robin arbiter with grant hold while the winner is stalled downstream.
module xadac_rr_arb #(
   parameter int unsigned NumReq = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NumReq-1:0] i_req,
   input  logic              i_lock,
   input  logic              i_ack,
   output logic [NumReq-1:0] o_gnt_c
);

   localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

   logic [PtrW-1:0]   r_ptr;
   logic              r_hold;
   logic [NumReq-1:0] r_hold_gnt;
   logic [NumReq-1:0] w_pick;
   logic [PtrW-1:0]   w_idx;
   logic [PtrW-1:0]   w_gnt_idx;
   int                w_j;

   // First requester at or after the pointer, wrapping.
   always_comb begin
      w_pick = '0;
      w_idx  = '0;
      w_j    = 0;
      for (int k = 0; k < int'(NumReq); k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= int'(NumReq)) w_j = w_j - int'(NumReq);
         w_idx = PtrW'(w_j);
         if ((w_pick == '0) && i_req[w_idx]) w_pick[w_idx] = 1'b1;
      end
   end

   assign o_gnt_c = r_hold ? r_hold_gnt : w_pick;

   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         if (o_gnt_c[i]) w_gnt_idx = PtrW'(i);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ptr      <= '0;
         r_hold     <= 1'b0;
         r_hold_gnt <= '0;
      end else begin
         r_hold     <= i_lock;
         r_hold_gnt <= o_gnt_c;
         if (i_ack) begin
            r_ptr <= (w_gnt_idx == PtrW'(NumReq - 1)) ? '0 : w_gnt_idx + PtrW'(1);
         end
      end
   end

endmodule

// File: rtl/xadac_dispatch.sv
// Fans a core's decode request out to all accelerators, records the accepting port per id,
// and routes later execute requests/responses through that table.
module xadac_dispatch
   import xadac_pkg::*;
#(
   parameter int unsigned NumMst   = 2,
   parameter int unsigned TblDepth = 2**IdWidth
) (
   input  logic  clk,
   input  logic  rstn,
   xadac_if.slv  slv,
   xadac_if.mst  mst [NumMst],
   output logic  unmapped_o
);

   localparam int unsigned SelW = (NumMst > 1) ? $clog2(NumMst) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_RESP
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   dec_req_t          r_dec_req;
   logic [NumMst-1:0] r_cap;
   dec_rsp_t          r_rsp [NumMst];
   route_t            r_tbl [TblDepth];

   logic [NumMst-1:0] w_mdec_req_vld;
   logic [NumMst-1:0] w_mdec_rsp_vld;
   logic [NumMst-1:0] w_cap_set;
   dec_rsp_t          w_mdec_rsp [NumMst];
   logic              w_req_load;
   logic              w_tbl_we;
   logic [SelW-1:0]   w_win;
   logic              w_acc_any;
   dec_rsp_t          w_slv_rsp;
   logic              w_slv_rsp_vld;
   logic              w_slv_req_rdy;

   route_t            w_ent;
   logic [NumMst-1:0] w_exe_sel;
   logic [NumMst-1:0] w_mexe_req_rdy;
   logic              w_exe_rdy;

   logic [NumMst-1:0] w_mexe_rsp_vld;
   exe_rsp_t          w_mexe_rsp [NumMst];
   logic [NumMst-1:0] w_gnt;
   exe_rsp_t          w_slv_exe_rsp;
   logic              w_slv_exe_rsp_vld;

   // Lowest-index accepting port among captured responses.
   always_comb begin
      w_win     = '0;
      w_acc_any = 1'b0;
      for (int i = int'(NumMst) - 1; i >= 0; i--) begin
         if (r_rsp[i].accept) begin
            w_win     = SelW'(i);
            w_acc_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_req_load     = 1'b0;
      w_mdec_req_vld = '0;
      w_cap_set      = '0;
      w_slv_rsp_vld  = 1'b0;
      w_slv_rsp      = '0;
      w_slv_req_rdy  = 1'b0;
      w_tbl_we       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (slv.dec_req_valid) begin
               w_req_load  = 1'b1;
               w_state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            w_mdec_req_vld = ~r_cap;
            w_cap_set      = ~r_cap & w_mdec_rsp_vld;
            if (&r_cap) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_slv_rsp_vld = 1'b1;
            if (w_acc_any) w_slv_rsp    = r_rsp[w_win];
            else           w_slv_rsp.id = r_dec_req.id;
            if (slv.dec_rsp_ready) begin
               w_slv_req_rdy = 1'b1;
               w_tbl_we      = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dec_req <= '0;
         r_cap     <= '0;
         for (int i = 0; i < int'(NumMst); i++) r_rsp[i] <= '0;
      end else begin
         if (w_req_load) begin
            r_dec_req <= slv.dec_req;
            r_cap     <= '0;
         end else begin
            r_cap <= r_cap | w_cap_set;
         end
         for (int i = 0; i < int'(NumMst); i++) begin
            if (w_cap_set[i]) r_rsp[i] <= w_mdec_rsp[i];
         end
      end
   end

   // Registered write: a same-cycle execute lookup sees the previous entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int t = 0; t < int'(TblDepth); t++) r_tbl[t] <= '0;
      end else if (w_tbl_we) begin
         r_tbl[r_dec_req.id] <= '{valid: w_acc_any, port: PortW'(w_win)};
      end
   end

   always_comb begin
      w_ent = r_tbl[slv.exe_req.id];
      for (int i = 0; i < int'(NumMst); i++) begin
         w_exe_sel[i] = w_ent.valid && (w_ent.port == PortW'(i));
      end
   end

   assign w_exe_rdy  = slv.exe_req_valid & (w_ent.valid ? |(w_exe_sel & w_mexe_req_rdy) : 1'b1);
   assign unmapped_o = slv.exe_req_valid & ~w_ent.valid;

   always_comb begin
      w_slv_exe_rsp = '0;
      for (int i = 0; i < int'(NumMst); i++) begin
         if (w_gnt[i]) w_slv_exe_rsp = w_mexe_rsp[i];
      end
   end

   assign w_slv_exe_rsp_vld = |(w_gnt & w_mexe_rsp_vld);

   xadac_rr_arb #(
      .NumReq (NumMst)
   ) u_rsp_arb (
      .clk     (clk),
      .rstn    (rstn),
      .i_req   (w_mexe_rsp_vld),
      .i_lock  (w_slv_exe_rsp_vld & ~slv.exe_rsp_ready),
      .i_ack   (w_slv_exe_rsp_vld & slv.exe_rsp_ready),
      .o_gnt_c (w_gnt)
   );

   assign slv.dec_req_ready = w_slv_req_rdy;
   assign slv.dec_rsp_valid = w_slv_rsp_vld;
   assign slv.dec_rsp       = w_slv_rsp;
   assign slv.exe_req_ready = w_exe_rdy;
   assign slv.exe_rsp_valid = w_slv_exe_rsp_vld;
   assign slv.exe_rsp       = w_slv_exe_rsp;

   for (genvar g = 0; g < NumMst; g++) begin : g_port
      assign mst[g].dec_req_valid = w_mdec_req_vld[g];
      assign mst[g].dec_req       = w_mdec_req_vld[g] ? r_dec_req : '0;
      assign mst[g].dec_rsp_ready = w_mdec_req_vld[g];
      assign w_mdec_rsp_vld[g]    = mst[g].dec_rsp_valid;
      assign w_mdec_rsp[g]        = mst[g].dec_rsp;
      assign mst[g].exe_req_valid = w_exe_sel[g] & slv.exe_req_valid;
      assign mst[g].exe_req       = w_exe_sel[g] ? slv.exe_req : '0;
      assign w_mexe_req_rdy[g]    = mst[g].exe_req_ready;
      assign w_mexe_rsp_vld[g]    = mst[g].exe_rsp_valid;
      assign w_mexe_rsp[g]        = mst[g].exe_rsp;
      assign mst[g].exe_rsp_ready = w_gnt[g] & slv.exe_rsp_ready;
   end

endmodule

// File: tb/tb_xadac_dispatch.sv
// Directed bench for xadac_dispatch with two accelerator ports.
module tb_xadac_dispatch;
   import xadac_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic unmapped;
   int   n_cmp = 0;
   int   n_err = 0;

   xadac_if slv_if ();
   xadac_if mst_if [2] ();

   xadac_dispatch #(
      .NumMst (2)
   ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .slv        (slv_if),
      .mst        (mst_if),
      .unmapped_o (unmapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   initial begin
      dec_req_t q;
      dec_rsp_t er;
      exe_req_t xq;
      exe_rsp_t r0;
      exe_rsp_t r1;

      rstn = 1'b0;
      slv_if.dec_req_valid = 1'b0;
      slv_if.dec_req       = '0;
      slv_if.dec_rsp_ready = 1'b1;
      slv_if.exe_req_valid = 1'b0;
      slv_if.exe_req       = '0;
      slv_if.exe_rsp_ready = 1'b0;
      mst_if[0].dec_rsp_valid = 1'b1;
      mst_if[0].dec_rsp       = '0;
      mst_if[0].exe_req_ready = 1'b1;
      mst_if[0].exe_rsp_valid = 1'b0;
      mst_if[0].exe_rsp       = '0;
      mst_if[1].dec_rsp_valid = 1'b1;
      mst_if[1].dec_rsp       = '0;
      mst_if[1].exe_req_ready = 1'b1;
      mst_if[1].exe_rsp_valid = 1'b0;
      mst_if[1].exe_rsp       = '0;
      #2;
      chk("rst_dec_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      chk("rst_dec_req_ready", 64'(slv_if.dec_req_ready), 64'd0);
      chk("rst_m0_dec_req_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      chk("rst_exe_rsp_valid", 64'(slv_if.exe_rsp_valid), 64'd0);
      chk("rst_unmapped", 64'(unmapped), 64'd0);
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // id 5: port0 rejects, port1 accepts
      mst_if[0].dec_rsp = '{id: 3'd5, accept: 1'b0, flags: 4'h1};
      mst_if[1].dec_rsp = '{id: 3'd5, accept: 1'b1, flags: 4'hA};
      q = '{id: 3'd5, instr: 32'hDEAD0005};
      slv_if.dec_req = q;
      slv_if.dec_req_valid = 1'b1;
      samp();
      chk("t1_c0_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      tick();
      samp();
      chk("t1_c1_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd1);
      chk("t1_c1_m1_req_valid", 64'(mst_if[1].dec_req_valid), 64'd1);
      chk("t1_c1_m1_req", 64'(mst_if[1].dec_req), 64'(q));
      tick();
      samp();
      chk("t1_c2_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      chk("t1_c2_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      tick();
      samp();
      er = '{id: 3'd5, accept: 1'b1, flags: 4'hA};
      chk("t1_c3_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd1);
      chk("t1_c3_rsp", 64'(slv_if.dec_rsp), 64'(er));
      chk("t1_c3_req_ready", 64'(slv_if.dec_req_ready), 64'd1);
      tick();
      slv_if.dec_req_valid = 1'b0;
      xq = '{id: 3'd5, opa: 32'h12345678};
      slv_if.exe_req = xq;
      slv_if.exe_req_valid = 1'b1;
      samp();
      chk("t1_exe_m1_valid", 64'(mst_if[1].exe_req_valid), 64'd1);
      chk("t1_exe_m0_valid", 64'(mst_if[0].exe_req_valid), 64'd0);
      chk("t1_exe_m1_req", 64'(mst_if[1].exe_req), 64'(xq));
      chk("t1_exe_ready", 64'(slv_if.exe_req_ready), 64'd1);
      chk("t1_exe_unmapped", 64'(unmapped), 64'd0);
      mst_if[1].exe_req_ready = 1'b0;
      #1;
      chk("t1_exe_ready_bp", 64'(slv_if.exe_req_ready), 64'd0);
      mst_if[1].exe_req_ready = 1'b1;
      tick();
      slv_if.exe_req_valid = 1'b0;

      // id 3: both accept, lowest index wins
      mst_if[0].dec_rsp = '{id: 3'd3, accept: 1'b1, flags: 4'h2};
      mst_if[1].dec_rsp = '{id: 3'd3, accept: 1'b1, flags: 4'h3};
      slv_if.dec_req = '{id: 3'd3, instr: 32'h00000003};
      slv_if.dec_req_valid = 1'b1;
      tick();
      tick();
      tick();
      samp();
      er = '{id: 3'd3, accept: 1'b1, flags: 4'h2};
      chk("t2_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd1);
      chk("t2_rsp", 64'(slv_if.dec_rsp), 64'(er));
      tick();
      slv_if.dec_req_valid = 1'b0;
      slv_if.exe_req = '{id: 3'd3, opa: 32'h33};
      slv_if.exe_req_valid = 1'b1;
      samp();
      chk("t2_exe_m0_valid", 64'(mst_if[0].exe_req_valid), 64'd1);
      chk("t2_exe_m1_valid", 64'(mst_if[1].exe_req_valid), 64'd0);
      tick();
      slv_if.exe_req = '{id: 3'd5, opa: 32'h55};
      samp();
      chk("t2_id5_persist_m1", 64'(mst_if[1].exe_req_valid), 64'd1);
      chk("t2_id5_persist_m0", 64'(mst_if[0].exe_req_valid), 64'd0);
      tick();
      slv_if.exe_req_valid = 1'b0;

      // id 6: port1 holds dec_rsp_valid low for 4 cycles
      mst_if[0].dec_rsp = '{id: 3'd6, accept: 1'b0, flags: 4'h0};
      mst_if[1].dec_rsp = '{id: 3'd6, accept: 1'b1, flags: 4'h6};
      mst_if[1].dec_rsp_valid = 1'b0;
      slv_if.dec_req = '{id: 3'd6, instr: 32'h00000006};
      slv_if.dec_req_valid = 1'b1;
      tick();
      samp();
      chk("t3_c1_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd1);
      tick();
      samp();
      chk("t3_c2_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      chk("t3_c2_m1_req_valid", 64'(mst_if[1].dec_req_valid), 64'd1);
      tick();
      samp();
      chk("t3_c3_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      chk("t3_c3_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      tick();
      samp();
      chk("t3_c4_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      tick();
      mst_if[1].dec_rsp_valid = 1'b1;
      samp();
      chk("t3_c5_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      chk("t3_c5_m0_req_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      tick();
      samp();
      chk("t3_c6_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      chk("t3_c6_m1_req_valid", 64'(mst_if[1].dec_req_valid), 64'd0);
      tick();
      samp();
      er = '{id: 3'd6, accept: 1'b1, flags: 4'h6};
      chk("t3_c7_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd1);
      chk("t3_c7_rsp", 64'(slv_if.dec_rsp), 64'(er));
      tick();
      slv_if.dec_req_valid = 1'b0;

      // id 4: nobody accepts -> zero response carrying the id, entry invalid
      mst_if[0].dec_rsp = '{id: 3'd4, accept: 1'b0, flags: 4'hF};
      mst_if[1].dec_rsp = '{id: 3'd4, accept: 1'b0, flags: 4'hF};
      slv_if.dec_req = '{id: 3'd4, instr: 32'h00000004};
      slv_if.dec_req_valid = 1'b1;
      tick();
      tick();
      tick();
      samp();
      er = '{id: 3'd4, accept: 1'b0, flags: 4'h0};
      chk("t4_rsp", 64'(slv_if.dec_rsp), 64'(er));
      tick();
      slv_if.dec_req_valid = 1'b0;
      slv_if.exe_req = '{id: 3'd4, opa: 32'h44};
      slv_if.exe_req_valid = 1'b1;
      samp();
      chk("t4_exe_unmapped", 64'(unmapped), 64'd1);
      tick();

      // id 7 never decoded
      slv_if.exe_req = '{id: 3'd7, opa: 32'h77};
      samp();
      chk("t5_ready", 64'(slv_if.exe_req_ready), 64'd1);
      chk("t5_unmapped", 64'(unmapped), 64'd1);
      chk("t5_m0_valid", 64'(mst_if[0].exe_req_valid), 64'd0);
      chk("t5_m1_valid", 64'(mst_if[1].exe_req_valid), 64'd0);
      tick();
      slv_if.exe_req_valid = 1'b0;
      samp();
      chk("t5_unmapped_off", 64'(unmapped), 64'd0);
      tick();

      // exe response arbitration with downstream stall
      r0 = '{id: 3'd0, result: 32'h1111};
      r1 = '{id: 3'd1, result: 32'h2222};
      mst_if[0].exe_rsp = r0;
      mst_if[1].exe_rsp = r1;
      mst_if[0].exe_rsp_valid = 1'b1;
      mst_if[1].exe_rsp_valid = 1'b1;
      slv_if.exe_rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         samp();
         chk("t6_stall_rsp", 64'(slv_if.exe_rsp), 64'(r0));
         chk("t6_stall_m0_ready", 64'(mst_if[0].exe_rsp_ready), 64'd0);
         tick();
      end
      slv_if.exe_rsp_ready = 1'b1;
      samp();
      chk("t6_hs_rsp", 64'(slv_if.exe_rsp), 64'(r0));
      chk("t6_hs_m0_ready", 64'(mst_if[0].exe_rsp_ready), 64'd1);
      chk("t6_hs_m1_ready", 64'(mst_if[1].exe_rsp_ready), 64'd0);
      tick();
      mst_if[0].exe_rsp = '{id: 3'd0, result: 32'h3333};
      samp();
      chk("t6_next_rsp", 64'(slv_if.exe_rsp), 64'(r1));
      chk("t6_next_m1_ready", 64'(mst_if[1].exe_rsp_ready), 64'd1);
      chk("t6_next_m0_ready", 64'(mst_if[0].exe_rsp_ready), 64'd0);
      tick();

      // grant held on port1 while a pointer-favoured port0 arrives
      r1 = '{id: 3'd1, result: 32'h4444};
      r0 = '{id: 3'd0, result: 32'h5555};
      mst_if[0].exe_rsp_valid = 1'b0;
      mst_if[1].exe_rsp = r1;
      slv_if.exe_rsp_ready = 1'b0;
      samp();
      chk("t7_solo_rsp", 64'(slv_if.exe_rsp), 64'(r1));
      tick();
      mst_if[0].exe_rsp = r0;
      mst_if[0].exe_rsp_valid = 1'b1;
      samp();
      chk("t7_lock_rsp", 64'(slv_if.exe_rsp), 64'(r1));
      tick();
      slv_if.exe_rsp_ready = 1'b1;
      samp();
      chk("t7_lock_hs_m1_ready", 64'(mst_if[1].exe_rsp_ready), 64'd1);
      tick();
      mst_if[1].exe_rsp_valid = 1'b0;
      samp();
      chk("t7_after_rsp", 64'(slv_if.exe_rsp), 64'(r0));
      tick();
      mst_if[0].exe_rsp_valid = 1'b0;
      slv_if.exe_rsp_ready = 1'b0;

      // reset while collecting id 2
      mst_if[0].dec_rsp_valid = 1'b0;
      mst_if[1].dec_rsp_valid = 1'b0;
      slv_if.dec_req = '{id: 3'd2, instr: 32'h00000002};
      slv_if.dec_req_valid = 1'b1;
      tick();
      samp();
      chk("t8_collect_m0_valid", 64'(mst_if[0].dec_req_valid), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t8_async_m0_valid", 64'(mst_if[0].dec_req_valid), 64'd0);
      chk("t8_async_m1_valid", 64'(mst_if[1].dec_req_valid), 64'd0);
      chk("t8_async_rsp_valid", 64'(slv_if.dec_rsp_valid), 64'd0);
      slv_if.dec_req_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      slv_if.exe_req = '{id: 3'd2, opa: 32'h22};
      slv_if.exe_req_valid = 1'b1;
      samp();
      chk("t8_id2_unmapped", 64'(unmapped), 64'd1);
      chk("t8_id2_ready", 64'(slv_if.exe_req_ready), 64'd1);
      chk("t8_id2_m0_valid", 64'(mst_if[0].exe_req_valid), 64'd0);
      chk("t8_id2_m1_valid", 64'(mst_if[1].exe_req_valid), 64'd0);
      tick();
      slv_if.exe_req = '{id: 3'd5, opa: 32'h55};
      samp();
      chk("t8_id5_cleared", 64'(unmapped), 64'd1);
      tick();
      slv_if.exe_req_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
